// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART with TX/RX FIFOs.
//
// Frame: start (0), DATA_BITS data bits LSB first, optional parity bit, then
// STOP_BITS stop bits (1). Every bit is CLKS_PER_BIT clk cycles long.
// Each RX FIFO entry holds {parity_err, frame_err, data}.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   wr_en, d_in      push a character into the TX FIFO (ignored when full)
//   tx_full          TX FIFO full (registered)
//   rd_en            pop the RX FIFO head (ignored when empty)
//   d_out            RX FIFO head data, show-ahead, 0 when empty
//   rx_empty         RX FIFO empty (registered)
//   parity_err       parity error flag of the head character
//   frame_err        framing error flag of the head character
//   overrun          sticky, set when a received character is dropped; a pop clears it
//   tx_busy          TX FSM active or TX FIFO holding characters
//   tx               serial output, idle high
//   rx               serial input, asynchronous to clk
module uart_core_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] d_in,
  output logic                 tx_full,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_empty,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~(^d) : (^d);
  endfunction

  // Pointers carry one extra wrap bit: full when only the wrap bits differ.
  function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]        tx_wp, tx_rp, tx_wp_n, tx_rp_n;
  logic                 tx_empty, tx_push, tx_pop;
  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_level;

  // The FSM takes the next character from IDLE, or straight from the last
  // stop cycle so back-to-back characters leave no idle gap.
  assign tx_pop  = !tx_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == STOP_END)));
  // A push onto a full FIFO only lands when a pop frees a slot in the same cycle.
  assign tx_push = wr_en && (!tx_full || tx_pop);
  assign tx_wp_n = tx_wp + PW'(tx_push);
  assign tx_rp_n = tx_rp + PW'(tx_pop);
  assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      tx_wp    <= tx_wp_n;
      tx_rp    <= tx_rp_n;
      tx_full  <= ptr_full(tx_wp_n, tx_rp_n);
      tx_empty <= (tx_wp_n == tx_rp_n);
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= d_in;
  end

  // ----------------------------------------------------------------- TX FSM
  // NOTE: every path assigns tx_level after its default, so no latch is inferred.
  always_comb begin
    tx_level = 1'b1;
    case (tx_state)
      TX_START:  tx_level = 1'b0;
      TX_DATA:   tx_level = tx_data[tx_bit];
      TX_PARITY: tx_level = parity_of(tx_data);
      default:   tx_level = 1'b1;
    endcase
  end

  // tx is registered from the state, so the wire lags the FSM by one cycle;
  // the async reset still forces it high immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_data  <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_level;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_data  <= tx_mem[tx_rp[AW-1:0]];
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) tx_state <= (PARITY_MODE != 0) ? TX_PARITY : TX_STOP;
            else                    tx_bit   <= tx_bit + BW'(1);
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_PARITY: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_STOP;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        TX_STOP: begin
          if (tx_cnt == STOP_END) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_data  <= tx_mem[tx_rp[AW-1:0]];
              tx_state <= TX_START;
            end else tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + CW'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- RX FSM
  logic                 rx_s1, rx_s2, rx_prev;
  logic [2:0]           rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_perr, rx_wr, rx_pop;
  logic [EW-1:0]        rx_mem [FIFO_DEPTH];
  logic [EW-1:0]        rx_head;
  logic [PW-1:0]        rx_wp, rx_rp, rx_wp_n, rx_rp_n;
  logic                 rx_full;

  // The first stop-bit sample writes the character plus its error bits.
  assign rx_wr = (rx_state == RX_STOP) && (rx_cnt == BIT_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Re-check the line at mid start bit; a high level here is a glitch.
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_perr  <= 1'b0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= (PARITY_MODE != 0) ? RX_PARITY : RX_STOP;
            else                    rx_bit   <= rx_bit + BW'(1);
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_perr  <= (rx_s2 != parity_of(rx_shift));
            rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
          end else rx_cnt <= rx_cnt + CW'(1);
        end
        RX_WAIT_HIGH: begin
          // A break holds the line low; re-arm only once it is released.
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  assign rx_pop  = rd_en && !rx_empty;
  assign rx_wp_n = rx_wp + PW'(rx_wr && !rx_full);
  assign rx_rp_n = rx_rp + PW'(rx_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_full  <= 1'b0;
      rx_empty <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      rx_wp    <= rx_wp_n;
      rx_rp    <= rx_rp_n;
      rx_full  <= ptr_full(rx_wp_n, rx_rp_n);
      rx_empty <= (rx_wp_n == rx_rp_n);
      // A drop in the same cycle as a pop keeps the flag set.
      overrun  <= (overrun && !rx_pop) || (rx_wr && rx_full);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr && !rx_full) rx_mem[rx_wp[AW-1:0]] <= {rx_perr, !rx_s2, rx_shift};
  end

  assign rx_head    = rx_mem[rx_rp[AW-1:0]];
  assign d_out      = rx_empty ? '0 : rx_head[DATA_BITS-1:0];
  assign frame_err  = !rx_empty && rx_head[DATA_BITS];
  assign parity_err = !rx_empty && rx_head[EW-1];

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: CLKS_PER_BIT=4, 8 data bits, even
// parity, 1 stop bit, FIFO_DEPTH=4 (11-bit frame = 44 cycles). rx is either
// looped back from tx or driven by the bench. Expected RX entries
// {parity_err, frame_err, data} go into a queue as stimulus is driven and are
// popped when the DUT presents a character.
module tb_uart_core_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n, wr_en, rd_en, loop, rx_drv;
  logic [7:0] d_in, d_out;
  logic       tx_full, rx_empty, parity_err, frame_err, overrun, tx_busy, tx, rx;

  logic [9:0] sb [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  assign rx = loop ? tx : rx_drv;

  uart_core_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .d_in      (d_in),
    .tx_full   (tx_full),
    .rd_en     (rd_en),
    .d_out     (d_out),
    .rx_empty  (rx_empty),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .tx_busy   (tx_busy),
    .tx        (tx),
    .rx        (rx)
  );

  // Even parity reference.
  function automatic logic par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    d_in  = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    int k = 0;
    while (rx_empty && k < 300) begin
      step(1);
      k++;
    end
    check({tag, "_arrive"}, rx_empty, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (tx_busy && k < 500) begin
      step(1);
      k++;
    end
    check({tag, "_idle"}, tx_busy, 0);
  endtask

  task automatic read_check(input string tag);
    logic [9:0] exp;
    wait_rx(tag);
    exp = (sb.size() != 0) ? sb.pop_front() : 10'h3ff;
    check({tag, "_data"}, d_out, exp[7:0]);
    check({tag, "_perr"}, parity_err, exp[9]);
    check({tag, "_ferr"}, frame_err, exp[8]);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop);
    rx_drv = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      step(CPB);
    end
    rx_drv = par(d) ^ flip;
    step(CPB);
    rx_drv = stop;
    step(CPB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] full_seq;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    d_in    = '0;
    loop    = 1'b1;
    rx_drv  = 1'b1;
    step(3);
    check("rst_tx", tx, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_d_out", d_out, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tx_busy", tx_busy, 0);
    reset_n = 1'b1;
    step(2);

    // Loopback, TX latency: push sampled at edge N, tx low from edge N+2.
    push(8'hAA);
    check("lat_n0", tx, 1);
    check("busy_after_push", tx_busy, 1);
    step(1);
    check("lat_n1", tx, 1);
    step(1);
    check("lat_n2", tx, 0);
    sb.push_back({2'b00, 8'hAA});
    push(8'hCC);
    sb.push_back({2'b00, 8'hCC});
    read_check("lb_aa");
    read_check("lb_cc");
    wait_idle("lb");

    // Parity bit on the wire: 8'h07 has three ones, even parity bit = 1.
    // Data bit 7 occupies tx after edges N+34..N+37, parity N+38..N+41.
    push(8'h07);
    step(36);
    check("tx_bit7", tx, 0);
    step(4);
    check("tx_parity_bit", tx, par(8'h07));
    sb.push_back({2'b00, 8'h07});
    read_check("par_lb");
    wait_idle("par");

    // External frame with parity flipped.
    loop   = 1'b0;
    rx_drv = 1'b1;
    step(2);
    sb.push_back({2'b10, 8'h07});
    send_frame(8'h07, 1'b1, 1'b1);
    read_check("par_err");

    // Stop bit 0 with the line held low (break).
    sb.push_back({2'b01, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b0);
    step(3 * CPB - CPB);
    read_check("ferr");
    step(20);
    check("no_char_while_low", rx_empty, 1);
    rx_drv = 1'b1;
    step(CPB);
    sb.push_back({2'b00, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b1);
    read_check("rearm");

    // One-cycle glitch is rejected at the mid start-bit check.
    rx_drv = 1'b0;
    step(1);
    rx_drv = 1'b1;
    step(40);
    check("glitch_no_write", rx_empty, 1);
    sb.push_back({2'b00, 8'hC3});
    send_frame(8'hC3, 1'b0, 1'b1);
    read_check("after_glitch");

    // FIFO fill: six back-to-back pushes. The first character moves into the
    // TX shifter on the edge after its push, so the FIFO fills on push 5 and
    // push 6 is dropped. Chars 1..5 are looped back; RX keeps 4, drops 1.
    loop = 1'b1;
    step(2);
    full_seq = 6'b110000;
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_in = 8'(8'h11 * (i + 1));
      step(1);
      check($sformatf("tx_full_push%0d", i + 1), tx_full, full_seq[i]);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back({2'b00, 8'(8'h11 * (i + 1))});
    wait_idle("fill");
    step(10);
    check("overrun_set", overrun, 1);
    check("fifo_full_not_empty", rx_empty, 0);
    check("tx_full_drained", tx_full, 0);
    read_check("ovr0");
    check("overrun_cleared", overrun, 0);
    for (int i = 1; i < 4; i++) read_check($sformatf("ovr%0d", i));
    check("ovr_all_read", rx_empty, 1);

    // Reset mid data bit: leave one received character unread first.
    push(8'h81);
    wait_rx("pre_reset");
    wait_idle("pre_reset");
    push(8'h0F);
    step(22);
    check("tx_data_low", tx, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", tx_busy, 0);
    check("arst_rx_empty", rx_empty, 1);
    check("arst_tx_full", tx_full, 0);
    check("arst_d_out", d_out, 0);
    check("arst_flags", {parity_err, frame_err, overrun}, 0);
    sb.delete();
    step(3);
    reset_n = 1'b1;
    step(2);
    sb.push_back({2'b00, 8'h3C});
    push(8'h3C);
    read_check("post_reset");
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised successor to uart_top: a full-duplex UART with configurable frame format (data bits, parity, stop bits), a baud divider, and independent TX/RX FIFOs of configurable depth. The host side uses the same wr_en/d_in/tx_full and rd_en/d_out/rx_empty interface. The RX FIFO stores per-character parity and framing status alongside the data, and RX overrun is flagged. Sits between the host register interface and the pad-level tx/rx pins.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period (>=4, even)
DATA_BITS, 8, character width, 5..8
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, entries per FIFO, power of 2, >=2

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  push d_in into TX FIFO
d_in  input  DATA_BITS  TX character
tx_full  output  1  TX FIFO full
rd_en  input  1  pop RX FIFO head
d_out  output  DATA_BITS  RX FIFO head data (show-ahead)
rx_empty  output  1  RX FIFO empty
parity_err  output  1  parity error of the head character
frame_err  output  1  framing error of the head character
overrun  output  1  sticky: a received character was dropped because the RX FIFO was full
tx_busy  output  1  TX FSM not idle or TX FIFO not empty
tx  output  1  serial out, idle high
rx  input  1  serial in, asynchronous to clk

Behaviour:
- Reset (asynchronous, reset_n=0): both FIFOs emptied; tx=1; tx_full=0; rx_empty=1; d_out=0; parity_err=0; frame_err=0; overrun=0; tx_busy=0; both FSMs go to IDLE. Asserting reset mid-frame aborts the frame immediately, and tx returns high in the same instant.
- Frame: start bit (0), DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits (1). Even parity bit = XOR of the data bits; odd parity bit = its inverse.
- TX FIFO push: wr_en while tx_full=1 is ignored, with no state change. A simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- TX FSM states and transitions: IDLE -> START -> DATA -> (PARITY if PARITY_MODE!=0) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops the head and enters START.
  - Each non-IDLE state holds tx for exactly CLKS_PER_BIT cycles, timed by a bit counter.
  - STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
  - Back-to-back characters have no idle gap.
- TX latency: wr_en sampled at edge N into an empty, idle TX path gives tx=0 from edge N+2.
- rx synchronisation: rx passes through a 2-flop synchroniser; all RX timing is relative to the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a falling edge on rx enters START.
  - START: samples rx at CLKS_PER_BIT/2. If 1, it is a false start: return to IDLE and write nothing. If 0, continue.
  - Bit sampling: each subsequent bit is sampled CLKS_PER_BIT cycles after the previous sample (mid-bit).
  - PARITY: the received parity bit is compared with the computed parity; a mismatch sets parity_err for this character.
  - STOP: samples only the first stop bit; 0 sets frame_err for this character. The character plus its two error bits is written to the RX FIFO at that sample.
  - After a frame error the FSM goes to WAIT_HIGH and re-arms only after rx=1 (break handling). Otherwise it returns to IDLE.
- RX FIFO full at write time: the character is dropped, FIFO contents are unchanged, and overrun is set to 1. overrun clears on the next accepted rd_en pop.
- RX FIFO read: d_out, parity_err and frame_err always reflect the head entry. Each is 0 when empty. rd_en on an empty FIFO is ignored.
- Pointers: FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full = MSBs differ and remaining bits equal.
- Flag timing: tx_full and rx_empty are registered and update on the edge after the push or pop.
- tx and rx are independent; simultaneous TX and RX activity is required to work.

Test Plan:
1. Loopback (tx wired to rx), CLKS_PER_BIT=4, 8N1: write 8'hAA, then 8'hCC -> tx low at edge N+2; rx_empty falls after each frame (40 cycles per frame); reads return AA, then CC; parity_err=frame_err=0.
2. PARITY_MODE=1, loopback, write 8'h07 -> parity bit on tx = 1, received with parity_err=0. Then drive rx externally with the parity bit flipped -> head shows d_out=07, parity_err=1.
3. Drive a frame with stop bit 0 and rx held low for 3 bit times -> frame_err=1 with the character in the FIFO. No second character is received until rx returns high.
4. FIFO_DEPTH=4: push 5 characters without serial activity -> tx_full=1 after 4 pushes, the 5th is ignored. Loopback 5 received frames without reading -> 4 stored, overrun=1; first rd_en clears overrun.
5. rx glitch low for 1 cycle (shorter than CLKS_PER_BIT/2) -> no FIFO write, RX back to IDLE.
6. Assert reset_n=0 mid TX data bit -> tx=1 immediately, tx_busy=0, rx_empty=1, all flags 0. After release, the next write transmits normally.
